// File: rtl/deser_reg.sv
// Serial-to-parallel receiver with per-word bit order and a single-entry output register.
// A completed word that finds the output register full is dropped and flags overflow.
module deser_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              en_i,
    input  logic                              dir_i,
    input  logic                              clr_i,
    input  logic                              ser_vld_i,
    input  logic                              ser_dat_i,
    input  logic                              par_rdy_i,
    output logic                              par_vld_o,
    output logic [DATA_WIDTH-1:0]             par_dat_o,
    output logic                              busy_o,
    output logic [$clog2(DATA_WIDTH+1)-1:0]   bit_cnt_o,
    output logic                              ovf_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         bitCnt_q, bitCnt_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic                  dir_q, dir_d;
    logic                  parVld_q, parVld_d;
    logic [DATA_WIDTH-1:0] parDat_q, parDat_d;
    logic                  ovf_q, ovf_d;

    logic accept;
    logic wordDir;
    logic lastBit;

    assign accept  = ser_vld_i & en_i;
    // The first bit of a word picks the direction; later bits use the latched one.
    assign wordDir = (state_q == IDLE) ? dir_i : dir_q;
    assign lastBit = (bitCnt_q == CW'(DATA_WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        sr_d     = sr_q;
        dir_d    = dir_q;
        parVld_d = parVld_q;
        parDat_d = parDat_q;
        ovf_d    = ovf_q;

        if (parVld_q && par_rdy_i) begin
            parVld_d = 1'b0;
        end

        if (clr_i) begin
            state_d  = IDLE;
            bitCnt_d = '0;
            sr_d     = '0;
            ovf_d    = 1'b0;
        end else if (accept) begin
            if (wordDir) begin
                sr_d = {sr_q[DATA_WIDTH-2:0], ser_dat_i};
            end else begin
                sr_d = {ser_dat_i, sr_q[DATA_WIDTH-1:1]};
            end
            if (state_q == IDLE) begin
                dir_d = dir_i;
            end
            if (lastBit) begin
                state_d  = IDLE;
                bitCnt_d = '0;
                // Load only if the output register is empty or draining this cycle.
                if (!parVld_q || par_rdy_i) begin
                    parVld_d = 1'b1;
                    parDat_d = sr_d;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                state_d  = RECV;
                bitCnt_d = bitCnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            sr_q     <= '0;
            dir_q    <= 1'b0;
            parVld_q <= 1'b0;
            parDat_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            sr_q     <= sr_d;
            dir_q    <= dir_d;
            parVld_q <= parVld_d;
            parDat_q <= parDat_d;
            ovf_q    <= ovf_d;
        end
    end

    assign par_vld_o = parVld_q;
    assign par_dat_o = parDat_q;
    assign busy_o    = (state_q == RECV);
    assign bit_cnt_o = bitCnt_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_deser_reg.sv
// Self-checking bench for deser_reg (DATA_WIDTH=8): vector table plus corner-case sequences,
// with a scoreboard queue compared against every output handshake.
module tb_deser_reg;

    logic       clk_i;
    logic       rst_i;
    logic       en_i;
    logic       dir_i;
    logic       clr_i;
    logic       ser_vld_i;
    logic       ser_dat_i;
    logic       par_rdy_i;
    logic       par_vld_o;
    logic [7:0] par_dat_o;
    logic       busy_o;
    logic [3:0] bit_cnt_o;
    logic       ovf_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] expQ[$];

    typedef struct {
        logic       dir;
        logic [7:0] seq;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    deser_reg #(.DATA_WIDTH(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .dir_i     (dir_i),
        .clr_i     (clr_i),
        .ser_vld_i (ser_vld_i),
        .ser_dat_i (ser_dat_i),
        .par_rdy_i (par_rdy_i),
        .par_vld_o (par_vld_o),
        .par_dat_o (par_dat_o),
        .busy_o    (busy_o),
        .bit_cnt_o (bit_cnt_o),
        .ovf_o     (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic dat);
        ser_vld_i = vld;
        ser_dat_i = dat;
        @(posedge clk_i);
        #1;
    endtask

    // seq[7] goes on the wire first; the expected word is pushed as the last bit is driven.
    task automatic sendWord(input logic dirv, input logic [7:0] seq, input logic pushExp,
                            input logic [7:0] expWord, input logic toggleDir, input logic rdyLast);
        dir_i = dirv;
        for (int i = 0; i < 8; i++) begin
            if (toggleDir && i == 3) dir_i = ~dirv;
            if (i == 7) begin
                par_rdy_i = rdyLast;
                if (pushExp) expQ.push_back(expWord);
            end
            applyStimulus(1'b1, seq[7-i]);
            if (i < 7) begin
                checkOutput("bit_cnt", {28'd0, bit_cnt_o}, 32'(i + 1));
                checkOutput("busy", {31'd0, busy_o}, 32'd1);
            end else begin
                checkOutput("bit_cnt_end", {28'd0, bit_cnt_o}, 32'd0);
                checkOutput("busy_end", {31'd0, busy_o}, 32'd0);
                if (pushExp) begin
                    checkOutput("vld_after_word", {31'd0, par_vld_o}, 32'd1);
                    checkOutput("dat_after_word", {24'd0, par_dat_o}, {24'd0, expWord});
                end
            end
        end
    endtask

    // Every handshake must deliver the oldest expected word.
    always @(negedge clk_i) begin
        if (!rst_i && par_vld_o && par_rdy_i) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_handshake: got %0h, expected no word at %0t", par_dat_o, $time);
            end else begin
                checkOutput("handshake_word", {24'd0, par_dat_o}, {24'd0, expQ.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b1; en_i = 1'b1; dir_i = 1'b1; clr_i = 1'b0;
        ser_vld_i = 1'b0; ser_dat_i = 1'b0; par_rdy_i = 1'b1;

        vecs[0] = '{dir: 1'b1, seq: 8'b11000001, exp: 8'hC1};
        vecs[1] = '{dir: 1'b0, seq: 8'b11000001, exp: 8'h83};
        vecs[2] = '{dir: 1'b1, seq: 8'h5A,       exp: 8'h5A};
        vecs[3] = '{dir: 1'b0, seq: 8'hF0,       exp: 8'h0F};
        vecs[4] = '{dir: 1'b1, seq: 8'h00,       exp: 8'h00};
        vecs[5] = '{dir: 1'b0, seq: 8'hFF,       exp: 8'hFF};
        vecs[6] = '{dir: 1'b0, seq: 8'b10010110, exp: 8'h69};

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_vld", {31'd0, par_vld_o}, 32'd0);
        checkOutput("rst_dat", {24'd0, par_dat_o}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_cnt", {28'd0, bit_cnt_o}, 32'd0);
        checkOutput("rst_ovf", {31'd0, ovf_o}, 32'd0);
        #2 rst_i = 1'b0;

        // Back-to-back words with dir_i flipped mid-word; no idle cycle between words.
        for (int k = 0; k < 7; k++) begin
            sendWord(vecs[k].dir, vecs[k].seq, 1'b1, vecs[k].exp, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("vld_cleared", {31'd0, par_vld_o}, 32'd0);

        // Overflow: second word dropped while the first is held.
        par_rdy_i = 1'b0;
        sendWord(1'b1, 8'hC1, 1'b1, 8'hC1, 1'b0, 1'b0);
        sendWord(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ovf_held_dat", {24'd0, par_dat_o}, 32'hC1);
        checkOutput("ovf_held_vld", {31'd0, par_vld_o}, 32'd1);
        checkOutput("ovf_set", {31'd0, ovf_o}, 32'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ovf_stable_dat", {24'd0, par_dat_o}, 32'hC1);
        par_rdy_i = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("ovf_drained_vld", {31'd0, par_vld_o}, 32'd0);
        checkOutput("ovf_sticky", {31'd0, ovf_o}, 32'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ovf_sticky2", {31'd0, ovf_o}, 32'd1);
        clr_i = 1'b1;
        applyStimulus(1'b0, 1'b0);
        clr_i = 1'b0;
        checkOutput("ovf_cleared", {31'd0, ovf_o}, 32'd0);

        // Word completes on the same edge as the handshake of the held word.
        par_rdy_i = 1'b0;
        sendWord(1'b1, 8'hC1, 1'b1, 8'hC1, 1'b0, 1'b0);
        clr_i = 1'b1;
        applyStimulus(1'b0, 1'b0);
        clr_i = 1'b0;
        checkOutput("clr_keeps_vld", {31'd0, par_vld_o}, 32'd1);
        checkOutput("clr_keeps_dat", {24'd0, par_dat_o}, 32'hC1);
        sendWord(1'b1, 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b1);
        checkOutput("same_edge_ovf", {31'd0, ovf_o}, 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("same_edge_drained", {31'd0, par_vld_o}, 32'd0);

        // clr_i mid-word, with a simultaneous serial bit that must be discarded.
        dir_i = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("pre_clr_cnt", {28'd0, bit_cnt_o}, 32'd4);
        clr_i = 1'b1;
        applyStimulus(1'b1, 1'b1);
        clr_i = 1'b0;
        checkOutput("clr_cnt", {28'd0, bit_cnt_o}, 32'd0);
        checkOutput("clr_busy", {31'd0, busy_o}, 32'd0);
        sendWord(1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);

        // Asynchronous reset mid-word with a held word: everything discarded.
        par_rdy_i = 1'b0;
        sendWord(1'b0, 8'hF0, 1'b1, 8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
        #2 rst_i = 1'b1;
        expQ.delete();
        #1;
        checkOutput("mid_rst_vld", {31'd0, par_vld_o}, 32'd0);
        checkOutput("mid_rst_dat", {24'd0, par_dat_o}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("mid_rst_cnt", {28'd0, bit_cnt_o}, 32'd0);
        checkOutput("mid_rst_ovf", {31'd0, ovf_o}, 32'd0);
        #2 rst_i = 1'b0;
        par_rdy_i = 1'b1;
        sendWord(1'b1, 8'h96, 1'b1, 8'h96, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);

        // Enable dropped mid-word; handshake of the held word still proceeds.
        par_rdy_i = 1'b0;
        sendWord(1'b1, 8'h11, 1'b1, 8'h11, 1'b0, 1'b0);
        dir_i = 1'b0;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("pre_en_cnt", {28'd0, bit_cnt_o}, 32'd3);
        en_i = 1'b0;
        par_rdy_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            applyStimulus(j != 1, 1'b0);
            checkOutput("en_off_cnt", {28'd0, bit_cnt_o}, 32'd3);
            if (j == 0) checkOutput("en_off_handshake", {31'd0, par_vld_o}, 32'd0);
        end
        en_i = 1'b1;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        expQ.push_back(8'h9D);
        applyStimulus(1'b1, 1'b1);
        checkOutput("en_word_dat", {24'd0, par_dat_o}, 32'h9D);
        applyStimulus(1'b0, 1'b0);

        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
